// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types, default geometry and helpers for the icache refill slice
//
// Contents:
//   state_e          refill FSM states (IDLE, REQ, FILL, WRITE)
//   DEF_*            default block/beat geometry
//   BEAT_COUNT       beats per block at the default geometry
//   OFFSET_W         byte-offset bits inside a block at the default geometry
//   block_align()    clears the in-block byte offset of an address
package icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FILL  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  localparam int unsigned DEF_BLOCK_WIDTH = 512;
  localparam int unsigned DEF_BEAT_WIDTH  = 64;
  localparam int unsigned BEAT_COUNT      = DEF_BLOCK_WIDTH / DEF_BEAT_WIDTH;
  localparam int unsigned OFFSET_W        = $clog2(DEF_BLOCK_WIDTH / 8);

  // Addresses up to 64 bits are aligned here; callers truncate to their width.
  function automatic logic [63:0] block_align(input logic [63:0] addr,
                                              input int unsigned  off_w);
    logic [63:0] mask;
    mask = ~64'd0 << off_w;
    return addr & mask;
  endfunction

endpackage

// File: rtl/icache_beat_asm.sv
// rtl/icache_beat_asm.sv - beat counter and block slot register for refill assembly
//
// Ports:
//   clk_i, arst_i   clock, asynchronous active-high reset
//   clear_i         zero counter and block (start of a new refill)
//   load_i          write beat_i into slot cnt, then advance cnt (wraps after last slot)
//   beat_i          incoming beat data
//   last_o          counter currently points at the final slot
//   block_o         assembled block, slot 0 in the LSBs
module icache_beat_asm #(
  parameter int BLOCK_WIDTH = 512,
  parameter int BEAT_WIDTH  = 64
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   clear_i,
  input  logic                   load_i,
  input  logic [BEAT_WIDTH-1:0]  beat_i,
  output logic                   last_o,
  output logic [BLOCK_WIDTH-1:0] block_o
);

  localparam int BEATS = BLOCK_WIDTH / BEAT_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0]       cnt_q;
  logic [BLOCK_WIDTH-1:0] block_q;

  assign last_o  = (cnt_q == CNT_MAX);
  assign block_o = block_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt_q   <= '0;
      block_q <= '0;
    end else if (clear_i) begin
      cnt_q   <= '0;
      block_q <= '0;
    end else if (load_i) begin
      block_q[cnt_q*BEAT_WIDTH +: BEAT_WIDTH] <= beat_i;
      // Explicit wrap keeps non-power-of-two beat counts correct.
      cnt_q <= last_o ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - miss detection, block read request and refill write for the icache
//
// Optional build macro: ICACHE_REFILL_PERF_EN adds saturating miss/stall counters.
//
// Ports:
//   clk_i, arst_i        clock, asynchronous active-high reset
//   fetch_req_i, addr_i  fetch lookup valid and address
//   hit_i                cache hit for addr_i
//   flush_i              redirect: abandon the refill in progress (beats still drained)
//   stall_o              fetch must hold
//   cache_we_o           one-cycle cache write enable
//   cache_addr_o         addr_i, or the latched miss address while writing
//   cache_block_o        assembled refill block
//   mem_req_*            block read request (valid/ready handshake, aligned address)
//   mem_rsp_*            response beats (always accepted) and last marker
//   err_o                sticky protocol error
//   perf_miss_cnt_o      (perf build) refills started
//   perf_stall_cnt_o     (perf build) cycles with stall_o high
module icache_refill
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH,
  parameter int BEAT_WIDTH  = DEF_BEAT_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   fetch_req_i,
  input  logic [ADDR_WIDTH-1:0]  addr_i,
  input  logic                   hit_i,
  input  logic                   flush_i,
  output logic                   stall_o,
  output logic                   cache_we_o,
  output logic [ADDR_WIDTH-1:0]  cache_addr_o,
  output logic [BLOCK_WIDTH-1:0] cache_block_o,
  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]  mem_req_addr_o,
  input  logic                   mem_rsp_valid_i,
  input  logic [BEAT_WIDTH-1:0]  mem_rsp_data_i,
  input  logic                   mem_rsp_last_i,
  output logic                   err_o
`ifdef ICACHE_REFILL_PERF_EN
 ,output logic [31:0]            perf_miss_cnt_o,
  output logic [31:0]            perf_stall_cnt_o
`endif
);

  localparam int unsigned OFF_W = $clog2(BLOCK_WIDTH / 8);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  abort_q;
  logic                  err_q;
  logic                  miss;
  logic                  start;
  logic                  asm_load;
  logic                  cnt_last;
  logic                  proto_err;

  assign miss = fetch_req_i & ~hit_i;

  icache_beat_asm #(
    .BLOCK_WIDTH (BLOCK_WIDTH),
    .BEAT_WIDTH  (BEAT_WIDTH)
  ) u_beat_asm (
    .clk_i   (clk_i),
    .arst_i  (arst_i),
    .clear_i (start),
    .load_i  (asm_load),
    .beat_i  (mem_rsp_data_i),
    .last_o  (cnt_last),
    .block_o (cache_block_o)
  );

  // Completion is decided by the beat counter; last only serves as a cross-check.
  assign proto_err = mem_rsp_valid_i &
                     ((state_q != ST_FILL) | (mem_rsp_last_i != cnt_last));

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        addr_q  <= addr_i;
        abort_q <= 1'b0;
      end else if (flush_i && (state_q == ST_REQ || state_q == ST_FILL)) begin
        abort_q <= 1'b1;
      end
      if (proto_err) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    stall_o         = 1'b1;
    cache_we_o      = 1'b0;
    cache_addr_o    = addr_i;
    mem_req_valid_o = 1'b0;
    start           = 1'b0;
    asm_load        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        stall_o = miss;
        if (miss && !flush_i) begin
          start   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (mem_rsp_valid_i) begin
          asm_load = 1'b1;
          // A flush on the final beat itself also cancels the write.
          if (cnt_last) begin
            state_d = (abort_q || flush_i) ? ST_IDLE : ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        cache_we_o   = 1'b1;
        cache_addr_o = addr_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_req_addr_o = ADDR_WIDTH'(block_align(64'(addr_q), OFF_W));
  assign err_o          = err_q;

`ifdef ICACHE_REFILL_PERF_EN
  logic [31:0] miss_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      miss_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (start && !(&miss_cnt_q)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
      if (stall_o && !(&stall_cnt_q)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign perf_miss_cnt_o  = miss_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_icache_refill.sv
// tb/tb_icache_refill.sv - directed scoreboard bench for icache_refill
module tb_icache_refill;
  import icache_pkg::*;

  logic         clk_i = 1'b0;
  logic         arst_i;
  logic         fetch_req_i;
  logic [63:0]  addr_i;
  logic         hit_i;
  logic         flush_i;
  logic         stall_o;
  logic         cache_we_o;
  logic [63:0]  cache_addr_o;
  logic [511:0] cache_block_o;
  logic         mem_req_valid_o;
  logic         mem_req_ready_i;
  logic [63:0]  mem_req_addr_o;
  logic         mem_rsp_valid_i;
  logic [63:0]  mem_rsp_data_i;
  logic         mem_rsp_last_i;
  logic         err_o;
`ifdef ICACHE_REFILL_PERF_EN
  logic [31:0]  perf_miss_cnt_o;
  logic [31:0]  perf_stall_cnt_o;
`endif

  icache_refill dut (
    .clk_i           (clk_i),
    .arst_i          (arst_i),
    .fetch_req_i     (fetch_req_i),
    .addr_i          (addr_i),
    .hit_i           (hit_i),
    .flush_i         (flush_i),
    .stall_o         (stall_o),
    .cache_we_o      (cache_we_o),
    .cache_addr_o    (cache_addr_o),
    .cache_block_o   (cache_block_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_data_i  (mem_rsp_data_i),
    .mem_rsp_last_i  (mem_rsp_last_i),
    .err_o           (err_o)
`ifdef ICACHE_REFILL_PERF_EN
   ,.perf_miss_cnt_o  (perf_miss_cnt_o),
    .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0]  addr;
    logic [511:0] blk;
  } wr_t;

  wr_t sb_q[$];
  int  checks = 0;
  int  errors = 0;
  int  hs_cnt = 0;
  int  wr_cnt = 0;

  localparam logic [63:0] SEED_A = 64'hA5A5_0000_0000_0000;
  localparam logic [63:0] SEED_B = 64'h1234_5678_0000_0000;
  localparam logic [63:0] SEED_C = 64'hDEAD_BEEF_0000_0000;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  // Scoreboard consumer: every cache write must match the oldest expected refill.
  always @(negedge clk_i) begin
    wr_t e;
    if (mem_req_valid_o === 1'b1 && mem_req_ready_i === 1'b1) hs_cnt++;
    if (cache_we_o === 1'b1) begin
      wr_cnt++;
      if (sb_q.size() == 0) begin
        chk("unexpected_write", {511'd0, cache_we_o}, 512'd0);
      end else begin
        e = sb_q.pop_front();
        chk("write_addr", {448'd0, cache_addr_o}, {448'd0, e.addr});
        chk("write_block", cache_block_o, e.blk);
      end
    end
  end

  // One miss-to-refill sequence. flush_beat >= 0 flushes after that beat index;
  // last_beat >= 0 raises mem_rsp_last_i early on that beat index.
  task automatic refill(input logic [63:0] a, input int rdy_dly, input int max_gap,
                        input int flush_beat, input int last_beat, input logic [63:0] seed);
    logic [511:0] b;
    int hs0;
    int gap;
    wr_t e;
    b = '0;
    for (int i = 0; i < BEAT_COUNT; i++) b[i*64 +: 64] = seed + 64'(i);
    if (flush_beat < 0) begin
      e.addr = a;
      e.blk  = b;
      sb_q.push_back(e);
    end
    hs0 = hs_cnt;
    cyc();
    fetch_req_i = 1'b1; addr_i = a; hit_i = 1'b0;
    smp();
    chk("miss_stall", {511'd0, stall_o}, 512'd1);
    chk("idle_no_req", {511'd0, mem_req_valid_o}, 512'd0);
    for (int k = 0; k <= rdy_dly; k++) begin
      cyc();
      mem_req_ready_i = (k == rdy_dly);
      smp();
      chk("req_valid", {511'd0, mem_req_valid_o}, 512'd1);
      chk("req_addr", {448'd0, mem_req_addr_o}, {448'd0, a & ~64'h3F});
      chk("req_stall", {511'd0, stall_o}, 512'd1);
    end
    cyc();
    mem_req_ready_i = 1'b0;
    for (int beat = 0; beat < BEAT_COUNT; beat++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 1)) : 0;
      if (flush_beat >= 0 && beat == flush_beat + 1 && gap == 0) gap = 1;
      for (int g = 0; g < gap; g++) begin
        flush_i = (flush_beat >= 0 && beat == flush_beat + 1 && g == 0);
        mem_rsp_valid_i = 1'b0;
        smp();
        chk("gap_stall", {511'd0, stall_o}, 512'd1);
        chk("gap_no_write", {511'd0, cache_we_o}, 512'd0);
        cyc();
      end
      flush_i         = 1'b0;
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = seed + 64'(beat);
      mem_rsp_last_i  = (beat == BEAT_COUNT - 1) || (beat == last_beat);
      smp();
      chk("fill_stall", {511'd0, stall_o}, 512'd1);
      chk("fill_no_req", {511'd0, mem_req_valid_o}, 512'd0);
      cyc();
    end
    mem_rsp_valid_i = 1'b0;
    mem_rsp_last_i  = 1'b0;
    if (flush_beat < 0) begin
      smp();
      chk("write_we", {511'd0, cache_we_o}, 512'd1);
      chk("write_stall", {511'd0, stall_o}, 512'd1);
      cyc();
      hit_i = 1'b1;
      smp();
      chk("post_write_stall", {511'd0, stall_o}, 512'd0);
      chk("post_write_we", {511'd0, cache_we_o}, 512'd0);
    end else begin
      hit_i = 1'b1;
      smp();
      chk("abort_no_write", {511'd0, cache_we_o}, 512'd0);
      chk("abort_idle_stall", {511'd0, stall_o}, 512'd0);
      chk("abort_idle_req", {511'd0, mem_req_valid_o}, 512'd0);
    end
    chk("one_handshake", 512'(hs_cnt - hs0), 512'd1);
    cyc();
    fetch_req_i = 1'b0;
    hit_i       = 1'b0;
  endtask

  initial begin
    arst_i = 1'b1;
    fetch_req_i = 1'b0; addr_i = '0; hit_i = 1'b0; flush_i = 1'b0;
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_data_i = '0; mem_rsp_last_i = 1'b0;

    smp();
    chk("rst_stall", {511'd0, stall_o}, 512'd0);
    chk("rst_we", {511'd0, cache_we_o}, 512'd0);
    chk("rst_req_valid", {511'd0, mem_req_valid_o}, 512'd0);
    chk("rst_req_addr", {448'd0, mem_req_addr_o}, 512'd0);
    chk("rst_err", {511'd0, err_o}, 512'd0);
    chk("rst_block", cache_block_o, 512'd0);
    cyc();
    arst_i = 1'b0;

    // Hits never start a refill.
    fetch_req_i = 1'b1; hit_i = 1'b1; addr_i = 64'h2000;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("hit_stall", {511'd0, stall_o}, 512'd0);
      chk("hit_no_req", {511'd0, mem_req_valid_o}, 512'd0);
      chk("hit_no_write", {511'd0, cache_we_o}, 512'd0);
      cyc();
    end
    fetch_req_i = 1'b0; hit_i = 1'b0;

    refill(64'h1044, 0, 0, -1, -1, SEED_A);   // cold miss, back-to-back beats
    refill(64'h3F78, 5, 0, -1, -1, SEED_B);   // request backpressure
    refill(64'h1044, 0, 3, -1, -1, SEED_A);   // gappy beats, same block expected
    refill(64'h5000, 1, 0, 3, -1, SEED_C);    // flush after beat 3
    smp();
    chk("err_after_flush", {511'd0, err_o}, 512'd0);

    refill(64'h6010, 0, 1, -1, 4, SEED_B);    // early last on the fifth beat
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("err_sticky", {511'd0, err_o}, 512'd1);
      cyc();
    end

    // Reset in the middle of FILL.
    fetch_req_i = 1'b1; addr_i = 64'h7000; hit_i = 1'b0;
    cyc();
    mem_req_ready_i = 1'b1;
    cyc();
    mem_req_ready_i = 1'b0;
    for (int beat = 0; beat < 3; beat++) begin
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = SEED_C + 64'(beat);
      cyc();
    end
    mem_rsp_valid_i = 1'b0;
    fetch_req_i     = 1'b0;
    arst_i          = 1'b1;
    #1;
    chk("midrst_stall", {511'd0, stall_o}, 512'd0);
    chk("midrst_we", {511'd0, cache_we_o}, 512'd0);
    chk("midrst_req_valid", {511'd0, mem_req_valid_o}, 512'd0);
    chk("midrst_req_addr", {448'd0, mem_req_addr_o}, 512'd0);
    chk("midrst_err", {511'd0, err_o}, 512'd0);
    chk("midrst_block", cache_block_o, 512'd0);
    cyc();
    arst_i = 1'b0;
    smp();
    chk("post_rst_we", {511'd0, cache_we_o}, 512'd0);

    refill(64'h7000, 0, 0, -1, -1, SEED_C);   // clean refill after reset

    smp();
    chk("sb_empty", 512'(sb_q.size()), 512'd0);
    chk("write_count", 512'(wr_cnt), 512'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Miss-handling and refill controller directly upstream of the direct-mapped instruction cache.
- Monitors fetch address and cache hit; on a miss, stalls fetch and issues one block read request to the memory side.
- Assembles BLOCK_WIDTH/BEAT_WIDTH response beats into one cache block.
- Drives the cache write port (write enable, address, block) for exactly one cycle.

Parameters:
- ADDR_WIDTH, 64, fetch/memory address width
- BLOCK_WIDTH, 512, cache block width in bits
- BEAT_WIDTH, 64, memory response data width per beat; BLOCK_WIDTH must be an integer multiple

Ports:
- clk_i  in  1  clock
- arst_i  in  1  asynchronous active-high reset
- fetch_req_i  in  1  fetch stage presents a valid addr_i this cycle
- addr_i  in  ADDR_WIDTH  fetch address
- hit_i  in  1  cache hit for addr_i
- flush_i  in  1  pipeline redirect; abandon the refill in progress
- stall_o  out  1  fetch must hold
- cache_we_o  out  1  cache write enable
- cache_addr_o  out  ADDR_WIDTH  cache address (addr_i, or latched miss address during WRITE)
- cache_block_o  out  BLOCK_WIDTH  assembled block
- mem_req_valid_o  out  1  block read request valid
- mem_req_ready_i  in  1  memory accepts request
- mem_req_addr_o  out  ADDR_WIDTH  block-aligned request address
- mem_rsp_valid_i  in  1  response beat valid (always accepted; no ready)
- mem_rsp_data_i  in  BEAT_WIDTH  response beat data
- mem_rsp_last_i  in  1  memory marks final beat
- err_o  out  1  sticky protocol error

Behaviour:
- Reset: arst_i is asynchronous, active-high; clock is clk_i.
- Reset values: state IDLE, beat counter 0, block register 0, abort flag 0, err_o 0.
- Reset values of outputs: cache_we_o 0, mem_req_valid_o 0, mem_req_addr_o 0.
- BEAT_COUNT = BLOCK_WIDTH/BEAT_WIDTH (8). The counter is $clog2(BEAT_COUNT) bits and wraps to 0 after the last beat.
- Alignment: mem_req_addr_o = latched address with its low $clog2(BLOCK_WIDTH/8) bits zeroed (6 bits by default).
- State IDLE:
  - stall_o = fetch_req_i & ~hit_i (combinational).
  - On fetch_req_i & ~hit_i & ~flush_i: latch addr_i, clear abort flag, go to REQ.
- State REQ:
  - mem_req_valid_o=1; mem_req_addr_o stays stable until mem_req_ready_i.
  - On handshake, go to FILL.
  - The request is never withdrawn once raised.
- State FILL:
  - Each mem_rsp_valid_i writes the beat into block slot cnt, bits [cnt*BEAT_WIDTH +: BEAT_WIDTH]; beat 0 is the LSBs. cnt then increments.
  - The beat accepted with cnt==BEAT_COUNT-1 moves the FSM to WRITE, or to IDLE if aborted.
- State WRITE:
  - cache_we_o=1 for exactly one cycle; cache_addr_o = latched address.
  - Then go to IDLE. The fetch at the same address hits on the following cycle.
- stall_o is 1 in REQ, FILL and WRITE.
- cache_addr_o = addr_i in every state except WRITE.
- Miss-to-write latency: 1 (REQ minimum) + BEAT_COUNT beats + 1 (WRITE) cycles at minimum.
- flush_i during REQ/FILL:
  - Sets the abort flag; the outstanding request still completes and all beats are drained.
  - No cache write occurs; return to IDLE after the final beat.
  - flush_i in IDLE or WRITE has no effect on the write in progress.
- mem_rsp_last_i:
  - The beat counter alone governs completion.
  - err_o is set (sticky until reset) if last is asserted with cnt≠BEAT_COUNT-1, or deasserted on the final counted beat.
- mem_rsp_valid_i outside FILL is ignored and sets err_o.
- Reset mid-refill returns immediately to IDLE with no write.

Optional Feature:
- Macro ICACHE_REFILL_PERF_EN.
- Defined: adds outputs perf_miss_cnt_o (32) and perf_stall_cnt_o (32), both reset to 0 and saturating at all-ones.
  - perf_miss_cnt_o increments on each IDLE→REQ transition.
  - perf_stall_cnt_o increments every cycle stall_o=1.
- Undefined: neither port nor counter exists.

Decomposition:
- Package icache_pkg: state enum (IDLE, REQ, FILL, WRITE), BEAT_COUNT and offset-width localparams, block-align function.
- Sub-module icache_beat_asm: counter plus block shift/slot register with load/clear controls, instantiated once.

Test Plan:
- Cold miss, addr 0x1044, hit_i=0, ready next cycle, 8 back-to-back beats 0x..00..0x..07:
  - mem_req_addr_o=0x1040.
  - cache_we_o pulses once with block[63:0]=beat0 and block[511:448]=beat7.
  - stall_o drops the cycle after WRITE.
- Hit, fetch_req_i=1 and hit_i=1: no request, stall_o=0, cache_we_o=0 throughout.
- Backpressure, mem_req_ready_i low 5 cycles: valid held, address stable, exactly one handshake.
- Gappy responses, beats with 1-3 idle cycles between them: block identical to the back-to-back case; WRITE follows the 8th beat.
- Flush in FILL after beat 3: remaining beats drained, no cache_we_o, state IDLE, err_o=0.
- Protocol error, mem_rsp_last_i on beat 5: err_o=1 and stays 1; refill still completes on beat 8.
- Reset asserted in FILL: all outputs return to reset values immediately.
